// File: rtl/dmem_pkg.sv
// Shared types, width constants and the access-check helper for the
// data-memory responder.
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;
  localparam int NBYTES = WORD_W / BYTE_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // An access faults when it is not word aligned or its word index lies
  // beyond the end of the array.
  function automatic logic access_err(input logic [WORD_W-1:0] addr,
                                      input int unsigned depth);
    return (addr[1:0] != 2'b00) || (32'(addr[WORD_W-1:2]) >= depth);
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Data-memory request/response bus: the processor side is the master,
// the memory responder is the slave.
interface data_mem_responder_if;
  import dmem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [WORD_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic [NBYTES-1:0] req_be;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WORD_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_bram.sv
// Word array split into byte lanes. A single commit strobe either writes
// the enabled lanes (store) or captures the addressed word into the read
// register (load). Contents are never reset.
module dmem_bram
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic              clk,
  input  logic              commit_i,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [NBYTES-1:0] be_i,
  output logic [WORD_W-1:0] rdata_o
);

  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [BYTE_W-1:0] rdata_q;

    // One lane: byte-gated write, registered read, both on commit.
    always_ff @(posedge clk) begin
      if (commit_i && we_i && be_i[gi]) begin
        mem_q[addr_i] <= wdata_i[gi*BYTE_W +: BYTE_W];
      end
      if (commit_i && !we_i) begin
        rdata_q <= mem_q[addr_i];
      end
    end

    assign rdata_o[gi*BYTE_W +: BYTE_W] = rdata_q;
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder: accepts one load/store, waits LATENCY cycles,
// commits to the array on the edge entering RESP and holds the response
// until the requester takes it.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic          clk,
  input  logic          rst,
  data_mem_responder_if.slave dmem
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              commit;
  logic              accept;

  logic              we_q;
  logic [WORD_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [NBYTES-1:0] be_q;

  logic              err_q;
  logic              rd_sel_q;

  // Operands of the commit: straight from the bus when committing in the
  // accept cycle (zero latency), otherwise from the latched request.
  logic              c_we;
  logic [WORD_W-1:0] c_addr;
  logic [WORD_W-1:0] c_wdata;
  logic [NBYTES-1:0] c_be;
  logic              c_err;
  logic              bram_commit;
  logic [WORD_W-1:0] bram_rdata;

  // Next-state logic and commit strobe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (dmem.req_valid) begin
          accept = 1'b1;
          if (LATENCY == 0) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (dmem.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Commit operand selection and access check.
  always_comb begin
    if (state_q == IDLE) begin
      c_we    = dmem.req_we;
      c_addr  = dmem.req_addr;
      c_wdata = dmem.req_wdata;
      c_be    = dmem.req_be;
    end else begin
      c_we    = we_q;
      c_addr  = addr_q;
      c_wdata = wdata_q;
      c_be    = be_q;
    end
    c_err = access_err(c_addr, DEPTH);
  end

  // A reset on the commit edge drops the transaction, so it must also
  // suppress the array write.
  assign bram_commit = commit && !c_err && !rst;

  // State, counter, latched request and response flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      err_q    <= 1'b0;
      rd_sel_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= dmem.req_we;
        addr_q  <= dmem.req_addr;
        wdata_q <= dmem.req_wdata;
        be_q    <= dmem.req_be;
      end
      if (commit) begin
        err_q    <= c_err;
        rd_sel_q <= !c_we && !c_err;
      end
    end
  end

  dmem_bram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_bram (
    .clk      (clk),
    .commit_i (bram_commit),
    .we_i     (c_we),
    .addr_i   (c_addr[AW+1:2]),
    .wdata_i  (c_wdata),
    .be_i     (c_be),
    .rdata_o  (bram_rdata)
  );

  assign dmem.req_ready = (state_q == IDLE);
  assign dmem.rsp_valid = (state_q == RESP);
  assign dmem.rsp_err   = (state_q == RESP) && err_q;
  assign dmem.rsp_rdata = ((state_q == RESP) && rd_sel_q) ? bram_rdata : '0;

endmodule
